multicycle_ctrl: RTL

Moore/Mealy control FSM that sequences a multicycle RV32I datapath. The datapath has a single shared instruction/data memory port, one ALU, the register file and non-architectural IR/OldPC/ALUOut/Data registers. Each instruction is split into FETCH, DECODE, EXECUTE, MEM and WB steps. All datapath mux selects and write enables for every cycle come from this block. It also stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller (master) and its datapath (slave).
// Carries decoded instruction fields in, and per-cycle mux selects and write enables out.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       ImmSrc;
  logic             RegWrite;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state, illegal, retired
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: drives datapath selects/enables each cycle, zero-latency Mealy outputs.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control, alu_dec;

  assign op        = bus.op;
  assign funct3    = bus.funct3;
  assign funct7b5  = bus.funct7b5;
  assign zero      = bus.zero;
  assign mem_ready = bus.mem_ready;

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    retire      = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU computes OldPC + imm now so BRANCH/JAL find the target in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        case (funct3)
          3'b000: begin
            pc_write = zero;
            retire   = 1'b1;
          end
          3'b001: begin
            pc_write = ~zero;
            retire   = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // A reset cycle must leave no architectural side effects behind
    if (rst) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegWrite   = reg_write;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;

endmodule
